// File: rtl/i2c_pkg.sv
// Shared types for the I2C master byte engine.
package i2c_pkg;

    localparam int I2C_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        HOLD,
        RSTART,
        STOP
    } state_t;

    typedef struct packed {
        logic                start;
        logic                stop;
        logic                read;
        logic                ack;
        logic [I2C_BITS-1:0] data;
    } cmd_t;

endpackage

// File: rtl/i2c_master_byte_engine_edge.sv
// Registered edge pulses from the prescaler SCL/SDA phase signals.
module i2c_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic scl_clk,
    input  logic sda_clk,
    output logic scl_q,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall
);

    logic sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q    <= 1'b0;
            sda_q    <= 1'b0;
            scl_fall <= 1'b0;
            sda_rise <= 1'b0;
            sda_fall <= 1'b0;
        end else begin
            scl_q    <= scl_clk;
            sda_q    <= sda_clk;
            scl_fall <= scl_q & ~scl_clk;
            sda_rise <= ~sda_q & sda_clk;
            sda_fall <= sda_q & ~sda_clk;
        end
    end

endmodule

// File: rtl/i2c_master_byte_engine.sv
// Byte-level I2C master: START / byte+ACK / repeated START / STOP.
// Define I2C_NACK_AUTO_STOP_EN to force STOP after a NACKed write.
module i2c_master_byte_engine
    import i2c_pkg::*;
(
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       scl_clk,
    input  logic       sda_clk,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_ack,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy
);

    state_t     state, state_n;
    cmd_t       cmd_q, cmd_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic       hold, hold_n;
    logic       scl_oe_n, sda_oe_n, cmd_ready_n, busy_n;
    logic       rsp_valid_n, nack_n;
    logic [7:0] rsp_data_n;
    logic       scl_q, scl_fall, sda_rise, sda_fall;
    logic       accept, scl_run, auto_stop, tx_bit;

    i2c_edge_detect u_edge (
        .clk      (sys_clk),
        .rst      (reset),
        .scl_clk  (scl_clk),
        .sda_clk  (sda_clk),
        .scl_q    (scl_q),
        .scl_fall (scl_fall),
        .sda_rise (sda_rise),
        .sda_fall (sda_fall)
    );

    assign accept = cmd_valid & cmd_ready;
    assign tx_bit = cmd_q.data[~bit_cnt[2:0]];
    // While stretching, SCL may finish its high phase but then stays low.
    assign scl_run = hold ? (scl_oe | ~scl_q) : ~scl_q;

`ifdef I2C_NACK_AUTO_STOP_EN
    assign auto_stop = ~cmd_q.read & sda_in;
`else
    assign auto_stop = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            bit_cnt   <= '0;
            hold      <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_nack  <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_q     <= cmd_n;
            bit_cnt   <= bit_cnt_n;
            hold      <= hold_n;
            scl_oe    <= scl_oe_n;
            sda_oe    <= sda_oe_n;
            cmd_ready <= cmd_ready_n;
            busy      <= busy_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_nack  <= nack_n;
        end
    end

    always_comb begin
        state_n     = state;
        cmd_n       = cmd_q;
        bit_cnt_n   = bit_cnt;
        hold_n      = hold;
        scl_oe_n    = scl_oe;
        sda_oe_n    = sda_oe;
        cmd_ready_n = cmd_ready;
        busy_n      = busy;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        nack_n      = rsp_nack;
        unique case (state)
            IDLE: begin
                scl_oe_n    = 1'b0;
                sda_oe_n    = 1'b0;
                cmd_ready_n = 1'b1;
                busy_n      = 1'b0;
                if (accept) begin
                    cmd_n       = {cmd_start, cmd_stop, cmd_read,
                                   cmd_ack, cmd_data};
                    cmd_ready_n = 1'b0;
                    busy_n      = 1'b1;
                    state_n     = START;
                end
            end
            START: begin
                if (sda_fall) sda_oe_n = 1'b1;
                if (scl_fall && sda_oe) begin
                    scl_oe_n  = 1'b1;
                    hold_n    = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = BIT;
                end
            end
            BIT: begin
                scl_oe_n = scl_run;
                if (sda_rise) begin
                    sda_oe_n = ~cmd_q.read & ~tx_bit;
                    hold_n   = 1'b0;
                end
                if (sda_fall && !hold) begin
                    rsp_data_n = {rsp_data[6:0],
                                  cmd_q.read ? sda_in : tx_bit};
                    bit_cnt_n  = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(I2C_BITS - 1)) state_n = ACK;
                end
            end
            ACK: begin
                scl_oe_n = scl_run;
                if (sda_rise) sda_oe_n = cmd_q.read & cmd_q.ack;
                if (sda_fall) begin
                    rsp_valid_n = 1'b1;
                    nack_n      = cmd_q.read ? ~cmd_q.ack : sda_in;
                    bit_cnt_n   = bit_cnt + 4'd1;
                    if (cmd_q.stop || auto_stop) begin
                        state_n = STOP;
                    end else begin
                        state_n     = HOLD;
                        hold_n      = 1'b1;
                        cmd_ready_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                scl_oe_n = scl_run;
                if (accept) begin
                    cmd_n       = {cmd_start, cmd_stop, cmd_read,
                                   cmd_ack, cmd_data};
                    cmd_ready_n = 1'b0;
                    bit_cnt_n   = '0;
                    state_n     = cmd_start ? RSTART : BIT;
                end
            end
            RSTART: begin
                scl_oe_n = scl_run;
                if (sda_rise) begin
                    sda_oe_n = 1'b0;
                    hold_n   = 1'b0;
                end
                if (sda_fall && !hold) begin
                    sda_oe_n  = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = BIT;
                end
            end
            STOP: begin
                scl_oe_n = ~scl_q;
                if (sda_rise) sda_oe_n = 1'b1;
                if (sda_fall) begin
                    sda_oe_n    = 1'b0;
                    scl_oe_n    = 1'b0;
                    busy_n      = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// Self-checking bench for i2c_master_byte_engine with a bus-level slave model.
module tb_i2c_master_byte_engine;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       scl_clk, sda_clk;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic       cmd_start = 1'b0, cmd_stop = 1'b0;
    logic       cmd_read = 1'b0, cmd_ack = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid, rsp_nack;
    logic [7:0] rsp_data;
    logic       sda_in, scl_oe, sda_oe, busy;

    int errors = 0;
    int checks = 0;

    i2c_master_byte_engine dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .scl_clk   (scl_clk),
        .sda_clk   (sda_clk),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_read  (cmd_read),
        .cmd_ack   (cmd_ack),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .sda_in    (sda_in),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .busy      (busy)
    );

    always #10 sys_clk = ~sys_clk;

    // Prescaler model: 16 sys_clk per SCL period, SDA phase 90 deg shifted
    int ph;
    always @(posedge sys_clk or posedge reset)
        if (reset) ph <= 0;
        else ph <= (ph == 15) ? 0 : ph + 1;
    assign scl_clk = (ph < 8);
    assign sda_clk = (ph >= 12) || (ph < 4);

    // Open-drain bus and slave
    logic       slave_sda = 1'b1;
    logic       scl_b, sda_b;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       s_read = 1'b0, s_ack = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic [7:0] sh = 8'h00, bus_byte = 8'h00;
    logic       bus_ack = 1'b1;
    int         bitpos = -1;
    int         starts = 0, stops = 0;

    assign scl_b  = ~scl_oe;
    assign sda_b  = ~sda_oe & slave_sda;
    assign sda_in = sda_b;

    always @(posedge sys_clk) begin
        int nb;
        if (reset) begin
            bitpos    <= -1;
            slave_sda <= 1'b1;
        end else if (scl_b && scl_p && sda_p && !sda_b) begin
            starts <= starts + 1;
            bitpos <= -1;
        end else if (scl_b && scl_p && !sda_p && sda_b) begin
            stops <= stops + 1;
        end else if (!scl_p && scl_b) begin
            if (bitpos >= 0 && bitpos < 8) sh <= {sh[6:0], sda_b};
            else if (bitpos == 8) begin
                bus_byte <= sh;
                bus_ack  <= sda_b;
            end
        end else if (scl_p && !scl_b) begin
            nb = (bitpos == 8) ? 0 : bitpos + 1;
            bitpos <= nb;
            if (bitpos == 8) slave_sda <= 1'b1;
            else if (s_read) slave_sda <= (nb < 8) ? s_data[7-nb] : 1'b1;
            else slave_sda <= (nb == 8) ? s_ack : 1'b1;
        end
        scl_p <= scl_b;
        sda_p <= sda_b;
    end

    typedef struct packed {
        logic [7:0] data;
        logic       nack;
        logic [7:0] bus;
        logic       bus_ack;
    } exp_t;

    typedef struct packed {
        logic       st, sp, rd, ak;
        logic [7:0] data;
        logic [7:0] sdat;
        logic       sack;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    int   rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge sys_clk) begin
        if (reset !== 1'b1 && rsp_valid === 1'b1) begin
            exp_t e;
            rsp_cnt++;
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_nack", rsp_nack, e.nack);
                check("bus_byte", bus_byte, e.bus);
                check("bus_ack", bus_ack, e.bus_ack);
            end
        end
    end

    task automatic send(input logic st, sp, rd, ak, input logic [7:0] d);
        int t = 0;
        @(negedge sys_clk);
        cmd_start = st;
        cmd_stop  = sp;
        cmd_read  = rd;
        cmd_ack   = ak;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 2000) begin
            @(negedge sys_clk);
            t++;
        end
        check("accept_timeout", cmd_ready, 1);
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge sys_clk);
            t++;
        end while (busy && t < 2000);
        check("idle_timeout", busy, 0);
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_cnt < n && t < 2000) begin
            @(negedge sys_clk);
            t++;
        end
        check("rsp_timeout", 32'(rsp_cnt >= n), 1);
    endtask

    vec_t vt[6];
    int   st0, sp0, r0, bad;

    initial begin
        vt[0] = {4'b1100, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
        vt[1] = {4'b1100, 8'h3C, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1};
        vt[2] = {4'b1110, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b1};
        vt[3] = {4'b1111, 8'h00, 8'hC3, 1'b0, 8'hC3, 1'b0, 8'hC3, 1'b0};
        vt[4] = {4'b1100, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[5] = {4'b1100, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};

        reset = 1'b1;
        #15;
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_nack", rsp_nack, 0);
        check("rst_busy", busy, 0);
        #5 reset = 1'b0;
        @(negedge sys_clk);
        check("ready_after_rst", cmd_ready, 1);

        for (int i = 0; i < 6; i++) begin
            s_read = vt[i].rd;
            s_data = vt[i].sdat;
            s_ack  = vt[i].sack;
            st0 = starts;
            sp0 = stops;
            r0  = rsp_cnt;
            sb.push_back(vt[i].e);
            send(vt[i].st, vt[i].sp, vt[i].rd, vt[i].ak, vt[i].data);
            wait_idle();
            check("vec_starts", starts - st0, 1);
            check("vec_stops", stops - sp0, 1);
            check("vec_rsp_cnt", rsp_cnt - r0, 1);
            check("vec_lines", {scl_oe, sda_oe}, 0);
        end

        // NACK on a write without cmd_stop
        s_read = 1'b0;
        s_ack  = 1'b1;
        st0 = starts;
        sp0 = stops;
        r0  = rsp_cnt;
        sb.push_back({8'h3C, 1'b1, 8'h3C, 1'b1});
        send(1, 0, 0, 0, 8'h3C);
        wait_rsp(r0 + 1);
`ifdef I2C_NACK_AUTO_STOP_EN
        wait_idle();
        check("autostop_stops", stops - sp0, 1);
        check("autostop_ready", cmd_ready, 1);
`else
        repeat (40) @(negedge sys_clk);
        check("nack_hold_busy", busy, 1);
        check("nack_hold_scl", scl_oe, 1);
        check("nack_hold_ready", cmd_ready, 1);
        check("nack_hold_nostop", stops - sp0, 0);
        s_ack = 1'b0;
        sb.push_back({8'h81, 1'b0, 8'h81, 1'b0});
        send(0, 1, 0, 0, 8'h81);
        wait_idle();
        check("nack_cont_stops", stops - sp0, 1);
        check("nack_cont_starts", starts - st0, 1);
`endif

        // Clock stretch: HOLD for 5 SCL periods, then continue
        s_read = 1'b0;
        s_ack  = 1'b0;
        st0 = starts;
        sp0 = stops;
        r0  = rsp_cnt;
        sb.push_back({8'hA0, 1'b0, 8'hA0, 1'b0});
        send(1, 0, 0, 0, 8'hA0);
        wait_rsp(r0 + 1);
        repeat (16) @(negedge sys_clk);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge sys_clk);
            if (scl_oe !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("stretch_scl_low", bad, 0);
        sb.push_back({8'h10, 1'b0, 8'h10, 1'b0});
        send(0, 1, 0, 0, 8'h10);
        wait_idle();
        check("stretch_starts", starts - st0, 1);
        check("stretch_stops", stops - sp0, 1);
        check("stretch_rsp_cnt", rsp_cnt - r0, 2);

        // Write then repeated-start read
        s_read = 1'b0;
        s_ack  = 1'b0;
        st0 = starts;
        sp0 = stops;
        r0  = rsp_cnt;
        sb.push_back({8'hA0, 1'b0, 8'hA0, 1'b0});
        send(1, 0, 0, 0, 8'hA0);
        wait_rsp(r0 + 1);
        s_read = 1'b1;
        s_data = 8'h96;
        sb.push_back({8'h96, 1'b1, 8'h96, 1'b1});
        send(1, 1, 1, 0, 8'h00);
        bad = 0;
        for (int t = 0; t < 2000 && rsp_cnt < r0 + 2; t++) begin
            @(negedge sys_clk);
            if (!busy) bad++;
        end
        check("rs_busy_held", bad, 0);
        check("rs_rsp_cnt", rsp_cnt - r0, 2);
        wait_idle();
        check("rs_starts", starts - st0, 2);
        check("rs_stops", stops - sp0, 1);

        // Reset during bit 4 of a write
        s_read = 1'b0;
        send(1, 1, 0, 0, 8'hF0);
        bad = 0;
        while (bitpos != 4 && bad < 2000) begin
            @(negedge sys_clk);
            bad++;
        end
        check("reach_bit4", bitpos, 4);
        repeat (3) @(negedge sys_clk);
        reset = 1'b1;
        #1;
        check("mid_rst_scl_oe", scl_oe, 0);
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 0);
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        s_ack = 1'b0;
        st0 = starts;
        sp0 = stops;
        sb.push_back({8'h81, 1'b0, 8'h81, 1'b0});
        send(1, 1, 0, 0, 8'h81);
        wait_idle();
        check("recover_starts", starts - st0, 1);
        check("recover_stops", stops - sp0, 1);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
